// File: rtl/key_ctrl_pkg.sv
// Shared types and defaults for the key load controller.
//   key_state_e        : controller state encoding (ST_ZERO exists only
//                        when KEY_ZEROIZE_EN is defined)
//   KEY_WORDS_DEF      : default number of words per key
//   KEY_WORD_SIZE_DEF  : default bits per key word
// Optional feature macro: KEY_ZEROIZE_EN
package key_ctrl_pkg;

  localparam int KEY_WORDS_DEF     = 4;
  localparam int KEY_WORD_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
`ifdef KEY_ZEROIZE_EN
    ,ST_ZERO  = 2'd3
`endif
  } key_state_e;

endpackage

// File: rtl/key_load_ctrl_rr_arbiter.sv
// Round-robin arbiter (module rr_arbiter).
// The search starts at the index after the last granted requester; the
// last-grant pointer only moves when en is high, so a grant can be
// evaluated every cycle but committed only when the owner is latched.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   req[NREQ]      : request vector
//   en             : commit the current grant as the new last owner
//   grant_idx      : index of the winning requester
//   grant_any      : at least one request is pending
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [IW-1:0] last_q, last_d;

  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_q) + i) % NREQ;
      if (!grant_any && req[cand]) begin
        grant_any = 1'b1;
        grant_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (en && grant_any) last_d = grant_idx;
  end

  // Reset points at the highest index so the first search begins at 0.
  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(NREQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/key_load_ctrl.sv
// Key load controller: arbitrates between key-word requesters, writes the
// granted requester's WORDS words into key storage, starts key expansion
// and reports the resulting key as valid.
// Optional feature macro: KEY_ZEROIZE_EN (adds zeroize input and ST_ZERO).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_wdata      : per-requester word offer
//   req_ready                : per-requester accept (owner in LOAD only)
//   ram_widx/ram_wen/ram_wdata : registered key storage write port
//   exp_start / exp_done     : key-expansion handshake
//   key_valid / key_owner    : key status and who loaded it
//   busy                     : not idle
//   zeroize                  : key erase request (KEY_ZEROIZE_EN only)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a requester; grant on any req_valid
// ST_LOAD   | accepting WORDS words from the owner
// ST_EXPAND | exp_start issued; waiting for exp_done
// ST_ZERO   | writing zeros to every key word (KEY_ZEROIZE_EN only)
import key_ctrl_pkg::*;

module key_load_ctrl #(
  parameter  int WORDS     = KEY_WORDS_DEF,
  parameter  int WORD_SIZE = KEY_WORD_SIZE_DEF,
  parameter  int NREQ      = 2,
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int OWN_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WORD_SIZE-1:0] req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic [IDX_W-1:0]          ram_widx,
  output logic                      ram_wen,
  output logic [WORD_SIZE-1:0]      ram_wdata,
  output logic                      exp_start,
  input  logic                      exp_done,
`ifdef KEY_ZEROIZE_EN
  input  logic                      zeroize,
`endif
  output logic                      key_valid,
  output logic [OWN_W-1:0]          key_owner,
  output logic                      busy
);

  key_state_e           state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic                 key_valid_q, key_valid_d;
  logic                 ram_wen_q, ram_wen_d;
  logic [IDX_W-1:0]     ram_widx_q, ram_widx_d;
  logic [WORD_SIZE-1:0] ram_wdata_q, ram_wdata_d;
  logic                 exp_start_q, exp_start_d;
  logic                 issued_q, issued_d;

  logic                 arb_en;
  logic [OWN_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [WORD_SIZE-1:0] owner_word;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign owner_word = req_wdata[int'(owner_q)*WORD_SIZE +: WORD_SIZE];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    key_valid_d = key_valid_q;
    ram_wen_d   = 1'b0;
    ram_widx_d  = ram_widx_q;
    ram_wdata_d = ram_wdata_q;
    exp_start_d = 1'b0;
    issued_d    = issued_q;
    arb_en      = 1'b0;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          arb_en      = 1'b1;
          owner_d     = arb_idx;
          key_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        req_ready[owner_q] = 1'b1;
        if (req_valid[owner_q]) begin
          ram_wen_d   = 1'b1;
          ram_widx_d  = cnt_q;
          ram_wdata_d = owner_word;
          if (cnt_q == IDX_W'(WORDS - 1)) begin
            cnt_d    = '0;
            issued_d = 1'b0;
            state_d  = ST_EXPAND;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_EXPAND: begin
        // exp_done is only meaningful after the exp_start pulse has gone out.
        if (!issued_q) begin
          exp_start_d = 1'b1;
          issued_d    = 1'b1;
        end else if (!exp_start_q && exp_done) begin
          key_valid_d = 1'b1;
          issued_d    = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`ifdef KEY_ZEROIZE_EN
      ST_ZERO: begin
        ram_wen_d   = 1'b1;
        ram_widx_d  = cnt_q;
        ram_wdata_d = '0;
        if (cnt_q == IDX_W'(WORDS - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef KEY_ZEROIZE_EN
    // Zeroize overrides everything decided above, including a grant or a
    // transfer in the same cycle, and restarts an erase already running.
    if (zeroize) begin
      req_ready   = '0;
      arb_en      = 1'b0;
      owner_d     = owner_q;
      key_valid_d = 1'b0;
      ram_wen_d   = 1'b0;
      ram_widx_d  = ram_widx_q;
      ram_wdata_d = ram_wdata_q;
      exp_start_d = 1'b0;
      issued_d    = 1'b0;
      cnt_d       = '0;
      state_d     = ST_ZERO;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      key_valid_q <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_widx_q  <= '0;
      ram_wdata_q <= '0;
      exp_start_q <= 1'b0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      key_valid_q <= key_valid_d;
      ram_wen_q   <= ram_wen_d;
      ram_widx_q  <= ram_widx_d;
      ram_wdata_q <= ram_wdata_d;
      exp_start_q <= exp_start_d;
      issued_q    <= issued_d;
    end
  end

  assign ram_wen   = ram_wen_q;
  assign ram_widx  = ram_widx_q;
  assign ram_wdata = ram_wdata_q;
  assign exp_start = exp_start_q;
  assign key_valid = key_valid_q;
  assign key_owner = owner_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed testbench for key_load_ctrl (WORDS=4, WORD_SIZE=32, NREQ=2).
// Define KEY_ZEROIZE_EN to include the zeroize scenarios.
module tb_key_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  ram_widx;
  logic        ram_wen;
  logic [31:0] ram_wdata;
  logic        exp_start;
  logic        exp_done;
  logic        zeroize;
  logic        key_valid;
  logic [0:0]  key_owner;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] w0 [4];
  logic [31:0] w1 [4];

  key_load_ctrl #(.WORDS(4), .WORD_SIZE(32), .NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .ram_widx  (ram_widx),
    .ram_wen   (ram_wen),
    .ram_wdata (ram_wdata),
    .exp_start (exp_start),
    .exp_done  (exp_done),
`ifdef KEY_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .key_valid (key_valid),
    .key_owner (key_owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_wdata = '0; exp_done = 1'b0; zeroize = 1'b0;
    tick(); tick();
    n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL rst_wen got %b exp 0", ram_wen); end
    n_vec++; if (ram_widx !== 2'd0) begin n_err++; $display("FAIL rst_widx got %0d exp 0", ram_widx); end
    n_vec++; if (ram_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got %h exp 0", ram_wdata); end
    n_vec++; if (exp_start !== 1'b0) begin n_err++; $display("FAIL rst_exp_start got %b exp 0", exp_start); end
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rst_key_valid got %b exp 0", key_valid); end
    n_vec++; if (key_owner !== 1'b0) begin n_err++; $display("FAIL rst_key_owner got %b exp 0", key_owner); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready got %b exp 00", req_ready); end
    rst = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic_load();
    req_valid = 2'b01;
    req_wdata = {32'h0, w0[0]};
    tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b exp 1", busy); end
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL basic_ready got %b exp 01", req_ready); end
    n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL basic_wen_grant got %b exp 0", ram_wen); end
    for (int i = 0; i < 4; i++) begin
      req_wdata = {32'h0, w0[i]};
      tick();
      n_vec++; if (ram_wen !== 1'b1) begin n_err++; $display("FAIL basic_wen[%0d] got %b exp 1", i, ram_wen); end
      n_vec++; if (ram_widx !== 2'(i)) begin n_err++; $display("FAIL basic_widx[%0d] got %0d exp %0d", i, ram_widx, i); end
      n_vec++; if (ram_wdata !== w0[i]) begin n_err++; $display("FAIL basic_wdata[%0d] got %h exp %h", i, ram_wdata, w0[i]); end
    end
    req_valid = 2'b00;
    n_vec++; if (exp_start !== 1'b0) begin n_err++; $display("FAIL basic_exp_early got %b exp 0", exp_start); end
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL basic_ready_expand got %b exp 00", req_ready); end
    tick();
    n_vec++; if (exp_start !== 1'b1) begin n_err++; $display("FAIL basic_exp_start got %b exp 1", exp_start); end
    n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL basic_wen_after got %b exp 0", ram_wen); end
    tick();
    n_vec++; if (exp_start !== 1'b0) begin n_err++; $display("FAIL basic_exp_pulse got %b exp 0", exp_start); end
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL basic_key_valid got %b exp 1", key_valid); end
    n_vec++; if (key_owner !== 1'b0) begin n_err++; $display("FAIL basic_key_owner got %b exp 0", key_owner); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 2'b11;
    req_wdata = {w1[0], w0[0]};
    tick();
    n_vec++; if (key_owner !== 1'b0) begin n_err++; $display("FAIL rr_owner0 got %b exp 0", key_owner); end
    for (int i = 0; i < 4; i++) begin
      req_wdata = {w1[i], w0[i]};
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rr_ready0[%0d] got %b exp 01", i, req_ready); end
      tick();
      n_vec++; if (ram_wdata !== w0[i]) begin n_err++; $display("FAIL rr_wdata0[%0d] got %h exp %h", i, ram_wdata, w0[i]); end
    end
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rr_ready_expand got %b exp 00", req_ready); end
    tick(); tick();
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL rr_key_valid0 got %b exp 1", key_valid); end
    tick();
    n_vec++; if (key_owner !== 1'b1) begin n_err++; $display("FAIL rr_owner1 got %b exp 1", key_owner); end
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rr_ready1 got %b exp 10", req_ready); end
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rr_grant_clears got %b exp 0", key_valid); end
    for (int i = 0; i < 4; i++) begin
      req_wdata = {w1[i], w0[i]};
      tick();
      n_vec++; if (ram_wdata !== w1[i] || ram_widx !== 2'(i)) begin n_err++; $display("FAIL rr_write1[%0d] got %h@%0d exp %h@%0d", i, ram_wdata, ram_widx, w1[i], i); end
    end
    req_valid = 2'b00;
    tick(); tick();
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    n_vec++; if (key_valid !== 1'b1 || key_owner !== 1'b1) begin n_err++; $display("FAIL rr_done1 got valid=%b owner=%b exp 1/1", key_valid, key_owner); end
  endtask

  task automatic test_gap();
    req_valid = 2'b01;
    tick();
    n_vec++; if (key_owner !== 1'b0) begin n_err++; $display("FAIL gap_owner got %b exp 0", key_owner); end
    for (int i = 0; i < 2; i++) begin
      req_wdata = {32'h0, w0[i]};
      tick();
      n_vec++; if (ram_wen !== 1'b1 || ram_widx !== 2'(i)) begin n_err++; $display("FAIL gap_pre[%0d] got wen=%b idx=%0d exp 1/%0d", i, ram_wen, ram_widx, i); end
    end
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (ram_wen !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL gap_stall[%0d] got wen=%b busy=%b exp 0/1", i, ram_wen, busy); end
    end
    req_valid = 2'b01;
    for (int i = 2; i < 4; i++) begin
      req_wdata = {32'h0, w0[i]};
      tick();
      n_vec++; if (ram_wen !== 1'b1 || ram_widx !== 2'(i) || ram_wdata !== w0[i]) begin n_err++; $display("FAIL gap_resume[%0d] got wen=%b idx=%0d data=%h exp 1/%0d/%h", i, ram_wen, ram_widx, ram_wdata, i, w0[i]); end
    end
    req_valid = 2'b00;
    tick();
    n_vec++; if (exp_start !== 1'b1) begin n_err++; $display("FAIL gap_exp_start got %b exp 1", exp_start); end
    tick();
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    n_vec++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL gap_key_valid got %b exp 1", key_valid); end
  endtask

  task automatic test_reset_mid_load();
    req_valid = 2'b10;
    tick();
    n_vec++; if (key_owner !== 1'b1) begin n_err++; $display("FAIL rml_owner got %b exp 1", key_owner); end
    for (int i = 0; i < 2; i++) begin
      req_wdata = {w1[i], 32'h0};
      tick();
    end
    n_vec++; if (ram_widx !== 2'd1 || ram_wen !== 1'b1) begin n_err++; $display("FAIL rml_pre got idx=%0d wen=%b exp 1/1", ram_widx, ram_wen); end
    req_wdata = {w1[2], 32'h0};
    rst = 1'b1;
    tick();
    n_vec++; if (ram_wen !== 1'b0 || ram_widx !== 2'd0 || ram_wdata !== 32'h0) begin n_err++; $display("FAIL rml_ram got wen=%b idx=%0d data=%h exp 0/0/0", ram_wen, ram_widx, ram_wdata); end
    n_vec++; if (busy !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL rml_busy got busy=%b ready=%b exp 0/00", busy, req_ready); end
    n_vec++; if (key_owner !== 1'b0 || key_valid !== 1'b0) begin n_err++; $display("FAIL rml_key got owner=%b valid=%b exp 0/0", key_owner, key_valid); end
    rst = 1'b0;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (exp_start !== 1'b0 || key_valid !== 1'b0 || ram_wen !== 1'b0) begin n_err++; $display("FAIL rml_after[%0d] got start=%b valid=%b wen=%b exp 0/0/0", i, exp_start, key_valid, ram_wen); end
    end
  endtask

  task automatic test_done_ignored();
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    n_vec++; if (key_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ign_idle got valid=%b busy=%b exp 0/0", key_valid, busy); end
    req_valid = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      req_wdata = {32'h0, w0[i]};
      tick();
    end
    req_valid = 2'b00;
    exp_done = 1'b1;
    tick();
    n_vec++; if (exp_start !== 1'b1) begin n_err++; $display("FAIL ign_exp_start got %b exp 1", exp_start); end
    tick();
    exp_done = 1'b0;
    n_vec++; if (key_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL ign_start_cycle got valid=%b busy=%b exp 0/1", key_valid, busy); end
    tick(); tick();
    n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL ign_wait got %b exp 0", key_valid); end
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    n_vec++; if (key_valid !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ign_late_done got valid=%b busy=%b exp 1/0", key_valid, busy); end
  endtask

`ifdef KEY_ZEROIZE_EN
  task automatic test_zeroize();
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    n_vec++; if (key_valid !== 1'b0 || busy !== 1'b1 || ram_wen !== 1'b0) begin n_err++; $display("FAIL zidle got valid=%b busy=%b wen=%b exp 0/1/0", key_valid, busy, ram_wen); end
    tick();
    n_vec++; if (ram_wen !== 1'b1 || ram_widx !== 2'd0) begin n_err++; $display("FAIL zidle_first got wen=%b idx=%0d exp 1/0", ram_wen, ram_widx); end
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL zrestart got wen=%b exp 0", ram_wen); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (ram_wen !== 1'b1 || ram_widx !== 2'(i) || ram_wdata !== 32'h0) begin n_err++; $display("FAIL zrestart_wr[%0d] got wen=%b idx=%0d data=%h exp 1/%0d/0", i, ram_wen, ram_widx, ram_wdata, i); end
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zrestart_idle got %b exp 0", busy); end
    req_valid = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      req_wdata = {32'h0, w0[i]};
      tick();
    end
    req_valid = 2'b00;
    tick();
    zeroize = 1'b1;
    exp_done = 1'b1;
    tick();
    zeroize = 1'b0;
    n_vec++; if (key_valid !== 1'b0 || ram_wen !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL zexp got valid=%b wen=%b busy=%b exp 0/0/1", key_valid, ram_wen, busy); end
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL zexp_ready[%0d] got %b exp 00", i, req_ready); end
      tick();
      n_vec++; if (ram_wen !== 1'b1 || ram_widx !== 2'(i) || ram_wdata !== 32'h0 || key_valid !== 1'b0) begin n_err++; $display("FAIL zexp_wr[%0d] got wen=%b idx=%0d data=%h valid=%b exp 1/%0d/0/0", i, ram_wen, ram_widx, ram_wdata, key_valid, i); end
    end
    req_valid = 2'b00;
    exp_done = 1'b0;
    n_vec++; if (busy !== 1'b0 || key_valid !== 1'b0) begin n_err++; $display("FAIL zexp_idle got busy=%b valid=%b exp 0/0", busy, key_valid); end
    tick();
    n_vec++; if (ram_wen !== 1'b0) begin n_err++; $display("FAIL zexp_end got wen=%b exp 0", ram_wen); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    w0[0] = 32'h00010203; w0[1] = 32'h04050607; w0[2] = 32'h08090A0B; w0[3] = 32'h0C0D0E0F;
    w1[0] = 32'hA0A1A2A3; w1[1] = 32'hB4B5B6B7; w1[2] = 32'hC8C9CACB; w1[3] = 32'hDCDDDEDF;
    test_reset();
    test_basic_load();
    test_round_robin();
    test_gap();
    test_reset_mid_load();
    test_done_ignored();
`ifdef KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
